// File: rtl/db_tupu_ram_sp_ctrl_pkg.sv
// Shared definitions for the deblocking top-row buffer controller.
// - Default data/address widths of the top-row buffer.
// - Single-port SRAM access encoding (cen/wen are active low).
// - Per-cycle SRAM slot owner used by the arbiter.
package db_tupu_ram_sp_ctrl_pkg;

  localparam int DB_TUPU_DAT_WD = 32;
  localparam int DB_TUPU_ADR_WD = 6;

  localparam logic SRAM_CEN_ON  = 1'b0;
  localparam logic SRAM_CEN_OFF = 1'b1;
  localparam logic SRAM_WEN_WR  = 1'b0;
  localparam logic SRAM_WEN_RD  = 1'b1;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_RD   = 2'd1,
    SLOT_WR   = 2'd2
  } slot_e;

endpackage

// File: rtl/db_tupu_ram_sp_ctrl_if.sv
// Read/write request bus of the top-row buffer controller.
// master: deblocking datapath (drives requests, sees ready/data/status).
// slave : controller.
// Signals: rd_req_i/rd_adr_i/rd_rdy_o/rd_vld_o/rd_dat_o (read port),
//          wr_req_i/wr_adr_i/wr_dat_i/wr_rdy_o (write port),
//          wbuf_cnt_o (holding FIFO occupancy), idle_o.
interface db_tupu_ram_sp_ctrl_if
  import db_tupu_ram_sp_ctrl_pkg::*;
#(
  parameter int DAT_WD   = DB_TUPU_DAT_WD,
  parameter int ADR_WD   = DB_TUPU_ADR_WD,
  parameter int WBUF_DEP = 2
);
  localparam int CNT_WD = $clog2(WBUF_DEP) + 1;

  logic              rd_req_i;
  logic [ADR_WD-1:0] rd_adr_i;
  logic              rd_rdy_o;
  logic              rd_vld_o;
  logic [DAT_WD-1:0] rd_dat_o;
  logic              wr_req_i;
  logic [ADR_WD-1:0] wr_adr_i;
  logic [DAT_WD-1:0] wr_dat_i;
  logic              wr_rdy_o;
  logic [CNT_WD-1:0] wbuf_cnt_o;
  logic              idle_o;

  modport master (
    output rd_req_i, rd_adr_i, wr_req_i, wr_adr_i, wr_dat_i,
    input  rd_rdy_o, rd_vld_o, rd_dat_o, wr_rdy_o, wbuf_cnt_o, idle_o
  );

  modport slave (
    input  rd_req_i, rd_adr_i, wr_req_i, wr_adr_i, wr_dat_i,
    output rd_rdy_o, rd_vld_o, rd_dat_o, wr_rdy_o, wbuf_cnt_o, idle_o
  );

endinterface

// File: rtl/db_tupu_ram_sp_ctrl_ram_1p.sv
// Parametrised single-port memory with a 1-cycle registered read.
// Ports: clk, cen (active-low enable), wen (active-low write), oen
// (active-low output enable), addr, d (write data), q (read data).
// XM_MODEL selects the hard macro; otherwise (RTL_MODEL or no define)
// the behavioural model is used. Contents are never reset.
module ram_1p
  import db_tupu_ram_sp_ctrl_pkg::*;
#(
  parameter int Word_Width = DB_TUPU_DAT_WD,
  parameter int Addr_Width = DB_TUPU_ADR_WD
) (
  input  logic                  clk,
  input  logic                  cen,
  input  logic                  wen,
  input  logic                  oen,
  input  logic [Addr_Width-1:0] addr,
  input  logic [Word_Width-1:0] d,
  output logic [Word_Width-1:0] q
);

`ifdef XM_MODEL
  sram_sp_hd #(
    .WORD_WIDTH (Word_Width),
    .ADDR_WIDTH (Addr_Width)
  ) u_macro (
    .CLK (clk),
    .CEN (cen),
    .WEN (wen),
    .OEN (oen),
    .A   (addr),
    .D   (d),
    .Q   (q)
  );
`else
  logic [Word_Width-1:0] mem [2**Addr_Width];
  logic [Word_Width-1:0] q_r;

  always_ff @(posedge clk) begin
    if (cen == SRAM_CEN_ON) begin
      if (wen == SRAM_WEN_WR) mem[addr] <= d;
      else                    q_r       <= mem[addr];
    end
  end

  assign q = oen ? '0 : q_r;
`endif

endmodule

// File: rtl/db_tupu_ram_sp_ctrl.sv
// Top-row buffer controller: logical read + write ports over one
// single-port SRAM.
// Ports: clk, rstn (async active-low), bus (slave side of
// db_tupu_ram_sp_ctrl_if).
// Writes are parked in a WBUF_DEP-entry holding FIFO and retired in
// slots without an accepted read. Reads own the SRAM by default and are
// forwarded from the newest matching pending FIFO entry. A full FIFO
// drops both ready flags so the next slot is a forced drain.
module db_tupu_ram_sp_ctrl
  import db_tupu_ram_sp_ctrl_pkg::*;
#(
  parameter int DAT_WD   = DB_TUPU_DAT_WD,
  parameter int ADR_WD   = DB_TUPU_ADR_WD,
  parameter int WBUF_DEP = 2
) (
  input logic                  clk,
  input logic                  rstn,
  db_tupu_ram_sp_ctrl_if.slave bus
);

  localparam int PTR_WD = $clog2(WBUF_DEP);
  localparam int CNT_WD = PTR_WD + 1;

  typedef struct packed {
    logic [ADR_WD-1:0] adr;
    logic [DAT_WD-1:0] dat;
  } wbuf_ent_t;

  wbuf_ent_t         wbuf [WBUF_DEP];
  logic [PTR_WD-1:0] wr_ptr, rd_ptr;
  logic [CNT_WD-1:0] cnt_q, cnt_nxt;
  logic              full_q, idle_q;
  logic              rd_acc, wr_acc, pop;
  slot_e             slot;

  logic              fwd_hit, fwd_hit_q;
  logic [DAT_WD-1:0] fwd_dat, fwd_dat_q;
  logic              rd_vld_q;

  logic              ram_cen, ram_wen;
  logic [ADR_WD-1:0] ram_adr;
  logic [DAT_WD-1:0] ram_din, ram_q;

  // Acceptance is gated with rstn so the SRAM stays deselected while
  // reset is held, even though the ready flags reset high.
  always_comb begin
    rd_acc = rstn & bus.rd_req_i & ~full_q;
    wr_acc = rstn & bus.wr_req_i & ~full_q;
    slot   = SLOT_IDLE;
    if (rd_acc)                      slot = SLOT_RD;
    else if (rstn && cnt_q != '0)    slot = SLOT_WR;
    pop     = (slot == SLOT_WR);
    ram_cen = (slot == SLOT_IDLE) ? SRAM_CEN_OFF : SRAM_CEN_ON;
    ram_wen = (slot == SLOT_WR)   ? SRAM_WEN_WR  : SRAM_WEN_RD;
    ram_adr = (slot == SLOT_WR)   ? wbuf[rd_ptr].adr : bus.rd_adr_i;
    ram_din = wbuf[rd_ptr].dat;
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (wr_acc && !pop)      cnt_nxt = cnt_q + CNT_WD'(1);
    else if (!wr_acc && pop) cnt_nxt = cnt_q - CNT_WD'(1);
  end

  // Walk entries oldest to newest from the head; a later match
  // overrides, so the newest pending write wins. Only FIFO state from
  // the start of the cycle is searched (read-before-write).
  always_comb begin
    logic [PTR_WD-1:0] idx;
    idx     = '0;
    fwd_hit = 1'b0;
    fwd_dat = '0;
    for (int k = 0; k < WBUF_DEP; k++) begin
      idx = rd_ptr + PTR_WD'(k);
      if (CNT_WD'(k) < cnt_q && wbuf[idx].adr == bus.rd_adr_i) begin
        fwd_hit = 1'b1;
        fwd_dat = wbuf[idx].dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) wbuf[wr_ptr] <= '{adr: bus.wr_adr_i, dat: bus.wr_dat_i};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      idle_q    <= 1'b1;
      rd_vld_q  <= 1'b0;
      fwd_hit_q <= 1'b0;
      fwd_dat_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_WD'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_WD'(1);
      cnt_q     <= cnt_nxt;
      full_q    <= (cnt_nxt == CNT_WD'(WBUF_DEP));
      // rd_acc this cycle is the read in flight next cycle.
      idle_q    <= (cnt_nxt == '0) && !rd_acc;
      rd_vld_q  <= rd_acc;
      fwd_hit_q <= rd_acc & fwd_hit;
      if (rd_acc) fwd_dat_q <= fwd_dat;
    end
  end

  ram_1p #(
    .Word_Width (DAT_WD),
    .Addr_Width (ADR_WD)
  ) u_ram (
    .clk  (clk),
    .cen  (ram_cen),
    .wen  (ram_wen),
    .oen  (1'b0),
    .addr (ram_adr),
    .d    (ram_din),
    .q    (ram_q)
  );

  assign bus.rd_rdy_o   = ~full_q;
  assign bus.wr_rdy_o   = ~full_q;
  assign bus.wbuf_cnt_o = cnt_q;
  assign bus.idle_o     = idle_q;
  assign bus.rd_vld_o   = rd_vld_q;
  assign bus.rd_dat_o   = !rd_vld_q ? '0 : (fwd_hit_q ? fwd_dat_q : ram_q);

endmodule

// File: doc/db_tupu_ram_sp_ctrl.md
# db_tupu_ram_sp_ctrl

Parametrised controller that gives the deblocking top-row buffer separate logical read and write ports over a single single-port SRAM. Writes are accepted into a small holding FIFO and retired into the SRAM in cycles with no read. Reads get the SRAM by default and are forwarded from pending FIFO entries on an address match. It sits between the deblocking filter datapath and the top-pixel/top-parameter storage, replacing direct macro instantiation.

## Interface
Parameters:
- DAT_WD, 32, data word width in bits
- ADR_WD, 6, address width; depth = 2**ADR_WD
- WBUF_DEP, 2, holding FIFO entries (power of two, 2..8)

Ports:
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- rd_req_i  in  1  read request
- rd_adr_i  in  ADR_WD  read address
- rd_rdy_o  out  1  read accepted when rd_req_i & rd_rdy_o
- rd_vld_o  out  1  read data valid
- rd_dat_o  out  DAT_WD  read data; 0 whenever rd_vld_o low
- wr_req_i  in  1  write request
- wr_adr_i  in  ADR_WD  write address
- wr_dat_i  in  DAT_WD  write data
- wr_rdy_o  out  1  write accepted when wr_req_i & wr_rdy_o
- wbuf_cnt_o  out  $clog2(WBUF_DEP)+1  FIFO occupancy
- idle_o  out  1  FIFO empty and no read in flight

## Operation
- Holding FIFO: entries (adr, dat), push on accepted write, pop on SRAM write retire; pointers wrap modulo WBUF_DEP.
- wr_rdy_o = !full. rd_rdy_o = !full. When the FIFO is full, the next slot is a forced drain.
- SRAM slot arbitration, evaluated every cycle:
  - Accepted read: SRAM read, cen=0, wen=1, addr=rd_adr_i.
  - Else, FIFO non-empty: SRAM write of the head entry, cen=0, wen=0, then pop.
  - Else: cen=1.
- Forwarding: an accepted read compares rd_adr_i against all valid FIFO entries as they stand at the start of the cycle. On a hit, the newest matching entry supplies the data, captured into a register, and the SRAM Q is ignored.
- A write accepted in the same cycle as a read is not visible to that read (read-before-write). It is visible to any later read.
- Push and pop in the same cycle leave occupancy unchanged.
- The occupancy reaches WBUF_DEP only via a push without a pop.
- SRAM contents are not reset; the FIFO, flags and pipeline registers are.
- Reset mid-operation discards pending FIFO writes and any in-flight read. No SRAM access occurs while rstn is low (cen=1).

## Timing
- Read latency is 1 cycle: a read accepted in cycle N gives rd_vld_o=1 in cycle N+1, with rd_dat_o = forwarded data or SRAM Q.
- Back-to-back reads sustain 1/cycle while the FIFO is not full.
- A write accepted in cycle N is retired no earlier than N+1, in the first slot with no accepted read.
- wr_rdy_o, rd_rdy_o, wbuf_cnt_o and idle_o are driven from registers only, with no combinational path from the request inputs.
- Reset values: rd_vld_o=0, rd_dat_o=0, wr_rdy_o=1, rd_rdy_o=1, wbuf_cnt_o=0, idle_o=1.

## Structure
- Shared package defines:
  - the default widths DB_TUPU_DAT_WD=32 and DB_TUPU_ADR_WD=6;
  - the SRAM access encoding (cen/wen active-low constants).
- One sub-module, ram_1p (Word_Width, Addr_Width): the parametrised single-port memory, with a 1-cycle registered read and oen tied 0. The macro selection (RTL model vs. hard macro) lives inside it under the existing RTL_MODEL/XM_MODEL defines.
- The FIFO and arbiter stay inline; no further sub-modules.

## Test plan
- Reset: hold rstn low with requests active. All outputs stay at their reset values and SRAM cen=1. Release; idle_o=1.
- Write then read, no collision: write adr 5 = 0xA5A5_0005, idle 3 cycles, read adr 5. Expect rd_vld_o one cycle later with 0xA5A5_0005; wbuf_cnt_o returns to 0 one cycle after the write.
- Forwarding newest wins:
  - Setup: reads held active so the FIFO does not drain; write adr 9 = 0x1111_1111, then adr 9 = 0x2222_2222.
  - Stimulus: next cycle, read adr 9 (FIFO now full).
  - Expect: rd_rdy_o=0 for one drain cycle; the read then returns 0x2222_2222.
- Same-cycle read/write to adr 3 (old value 0x0): the read returns 0x0 and the following read returns the new value.
- Full/backpressure with WBUF_DEP=2:
  - Stimulus: continuous reads plus 3 writes.
  - Expect: wr_rdy_o low after 2 pending writes, a forced drain cycle, no lost writes, and final SRAM contents correct for all addresses.
- Random soak at DAT_WD=64, ADR_WD=8, WBUF_DEP=4 against a reference memory model. Every rd_vld_o data matches, and rd_dat_o=0 whenever rd_vld_o=0.
